// File: rtl/intmul_sched_pkg.sv
// Shared types for the multiplier scheduler: issue tag layout and credit counter width.
package intmul_sched_pkg;

    localparam int ID_W   = 3;   // covers up to 8 requesters
    localparam int CRED_W = 9;   // credit counters hold 0..DEPTH for DEPTH up to 256

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/intmul_sched_rr_arbiter.sv
// Round-robin picker: first eligible requester strictly after ptr, wrapping modulo NREQ.
module rr_arbiter
    import intmul_sched_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] elig,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] grant
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && elig[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/intmul_sched.sv
// Shares one fixed-latency multiplier among NREQ requesters with credit-based
// per-requester result FIFOs and round-robin issue.
module intmul_sched
    import intmul_sched_pkg::*;
#(
    parameter int LOGA  = 60,
    parameter int LOGB  = 60,
    parameter int NREQ  = 4,
    parameter int LAT   = 3,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ*LOGA-1:0]        req_a,
    input  logic [NREQ*LOGB-1:0]        req_b,
    output logic [LOGA-1:0]             mul_a,
    output logic [LOGB-1:0]             mul_b,
    input  logic [LOGA+LOGB-1:0]        mul_c,
    output logic [NREQ-1:0]             rsp_valid,
    input  logic [NREQ-1:0]             rsp_ready,
    output logic [NREQ*(LOGA+LOGB)-1:0] rsp_data,
    output logic                        busy
);

    localparam int PW    = LOGA + LOGB;
    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [NREQ-1:0]   elig, grant, pop, fifo_full;
    logic              issue;
    logic [ID_W-1:0]   grant_id;
    tag_t              tag_out;

    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [CRED_W-1:0] credit_q [NREQ];
    logic [CRED_W-1:0] credit_d [NREQ];
    tag_t              tag_q [LAT];
    tag_t              tag_d [LAT];
    logic [PTR_W-1:0]  wr_ptr_q [NREQ];
    logic [PTR_W-1:0]  wr_ptr_d [NREQ];
    logic [PTR_W-1:0]  rd_ptr_q [NREQ];
    logic [PTR_W-1:0]  rd_ptr_d [NREQ];
    logic [PW-1:0]     mem_q [NREQ][DEPTH];
    logic [PW-1:0]     mem_d [NREQ][DEPTH];

    // A requester holding DEPTH credits stays ineligible even if it pops this cycle.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = rst && req_valid[i] && (credit_q[i] < CRED_W'(DEPTH));
        end
    end

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .elig  (elig),
        .ptr   (last_grant_q),
        .grant (grant)
    );

    always_comb begin
        issue     = |grant;
        req_ready = grant;
        grant_id  = '0;
        mul_a     = '0;
        mul_b     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                grant_id = ID_W'(i);
                mul_a    = req_a[i*LOGA +: LOGA];
                mul_b    = req_b[i*LOGB +: LOGB];
            end
        end
    end

    assign tag_out = tag_q[LAT-1];

    always_comb begin
        rsp_data = '0;
        busy     = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i] = rst && (wr_ptr_q[i] != rd_ptr_q[i]);
            fifo_full[i] = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                           (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
            rsp_data[i*PW +: PW] = mem_q[i][rd_ptr_q[i][AW-1:0]];
            busy = busy || (credit_q[i] != '0);
        end
        for (int s = 0; s < LAT; s++) begin
            busy = busy || tag_q[s].valid;
        end
        busy = busy && rst;
    end

    assign pop = rsp_valid & rsp_ready;

    always_comb begin
        last_grant_d = issue ? grant_id : last_grant_q;
        tag_d[0]     = '{valid: issue, id: grant_id};
        for (int s = 1; s < LAT; s++) begin
            tag_d[s] = tag_q[s-1];
        end
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        for (int i = 0; i < NREQ; i++) begin
            credit_d[i] = credit_q[i] + CRED_W'(grant[i]) - CRED_W'(pop[i]);
            if (pop[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
            end
            if (rst && tag_out.valid && (tag_out.id == ID_W'(i)) && !fifo_full[i]) begin
                mem_d[i][wr_ptr_q[i][AW-1:0]] = mul_c;
                wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant_q <= ID_W'(NREQ-1);
            for (int i = 0; i < NREQ; i++) begin
                credit_q[i] <= '0;
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
            for (int s = 0; s < LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            last_grant_q <= last_grant_d;
            credit_q     <= credit_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            tag_q        <= tag_d;
        end
    end

    // Result storage carries no reset; validity comes only from the pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_intmul_sched.sv
// Randomized bench for intmul_sched with a queue-based scoreboard and a delay-line multiplier.
module tb_intmul_sched;

    localparam int LOGA  = 60;
    localparam int LOGB  = 60;
    localparam int NREQ  = 4;
    localparam int LAT   = 3;
    localparam int DEPTH = 4;
    localparam int PW    = LOGA + LOGB;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NREQ*LOGA-1:0] req_a;
    logic [NREQ*LOGB-1:0] req_b;
    logic [LOGA-1:0]      mul_a;
    logic [LOGB-1:0]      mul_b;
    logic [PW-1:0]        mul_c;
    logic [NREQ*PW-1:0]   rsp_data;
    logic                 busy;

    intmul_sched #(.LOGA(LOGA), .LOGB(LOGB), .NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier: product appears LAT cycles after the operands.
    logic [PW-1:0] mpipe [LAT];
    always @(posedge clk) begin
        mpipe[0] <= {{LOGB{1'b0}}, mul_a} * {{LOGA{1'b0}}, mul_b};
        for (int s = 1; s < LAT; s++) mpipe[s] <= mpipe[s-1];
    end
    assign mul_c = mpipe[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        logic [PW-1:0] p;
        int            rdy;
    } ent_t;

    ent_t q [NREQ][$];
    int   lg = NREQ - 1;
    int   issue_cnt [NREQ];
    int   grant_log [$];
    int   pushed = 0;
    int   popped = 0;

    always @(negedge clk) begin : scoreboard
        int              eg;
        int              idx;
        logic [NREQ-1:0] er;
        logic            ev;
        logic            bsy;
        if (!rst) begin
            check_eq("rst_req_ready", req_ready, 0);
            check_eq("rst_rsp_valid", rsp_valid, 0);
            check_eq("rst_busy", busy, 0);
            check_eq("rst_mul_a", mul_a, 0);
            check_eq("rst_mul_b", mul_b, 0);
            for (int i = 0; i < NREQ; i++) q[i].delete();
            lg = NREQ - 1;
        end else begin
            eg = -1;
            for (int k = 1; k <= NREQ; k++) begin
                idx = (lg + k) % NREQ;
                if (eg < 0 && req_valid[idx] && q[idx].size() < DEPTH) eg = idx;
            end
            er = '0;
            if (eg >= 0) er[eg] = 1'b1;
            check_eq("req_ready", req_ready, er);
            check_eq("mul_a", mul_a, (eg >= 0) ? req_a[eg*LOGA +: LOGA] : '0);
            check_eq("mul_b", mul_b, (eg >= 0) ? req_b[eg*LOGB +: LOGB] : '0);
            bsy = 1'b0;
            for (int i = 0; i < NREQ; i++) if (q[i].size() > 0) bsy = 1'b1;
            check_eq("busy", busy, bsy);
            for (int i = 0; i < NREQ; i++) begin
                ev = (q[i].size() > 0) && (q[i][0].rdy <= cyc);
                check_eq($sformatf("rsp_valid%0d", i), rsp_valid[i], ev);
                if (ev) begin
                    check_eq($sformatf("rsp_data%0d", i), rsp_data[i*PW +: PW], q[i][0].p);
                    if (rsp_ready[i]) begin
                        void'(q[i].pop_front());
                        popped++;
                    end
                end
            end
            if (eg >= 0) begin
                q[eg].push_back('{p: {{LOGB{1'b0}}, req_a[eg*LOGA +: LOGA]} *
                                     {{LOGA{1'b0}}, req_b[eg*LOGB +: LOGB]},
                                  rdy: cyc + LAT + 1});
                lg = eg;
                issue_cnt[eg]++;
                grant_log.push_back(eg);
                pushed++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic rand_ops();
        logic [63:0] t;
        for (int i = 0; i < NREQ; i++) begin
            t = {$urandom(), $urandom()};
            req_a[i*LOGA +: LOGA] = t[LOGA-1:0];
            t = {$urandom(), $urandom()};
            req_b[i*LOGB +: LOGB] = t[LOGB-1:0];
        end
    endtask

    task automatic drain();
        int n;
        req_valid = '0;
        rsp_ready = '1;
        n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
        check_eq("drain_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int base_cnt [NREQ];
        int base_log;
        logic found;
        logic [63:0] big;

        rst = 1'b0;
        req_valid = '0;
        rsp_ready = '1;
        req_a = '0;
        req_b = '0;
        repeat (3) step();
        rst = 1'b1;
        repeat (5) step();

        // Single request 3*5 on requester 0.
        req_a[0 +: LOGA] = LOGA'(3);
        req_b[0 +: LOGB] = LOGB'(5);
        req_valid = 4'b0001;
        @(negedge clk);
        check_eq("single_ready", req_ready, 4'b0001);
        step();
        req_valid = '0;
        n = 0;
        found = 1'b0;
        while (n < 20 && !found) begin
            @(negedge clk);
            n++;
            if (rsp_valid[0]) found = 1'b1;
        end
        check_eq("single_latency", n, LAT + 1);
        check_eq("single_data", rsp_data[0 +: PW], 15);
        step();
        drain();

        // Fairness: all requesters valid right after reset.
        do_reset();
        for (int i = 0; i < NREQ; i++) base_cnt[i] = issue_cnt[i];
        base_log = grant_log.size();
        req_valid = '1;
        for (int c = 0; c < 40; c++) begin
            rand_ops();
            step();
        end
        req_valid = '0;
        for (int i = 0; i < NREQ; i++)
            check_eq($sformatf("fair_cnt%0d", i), issue_cnt[i] - base_cnt[i], 10);
        for (int k = 0; k < 8; k++)
            check_eq($sformatf("fair_order%0d", k), grant_log[base_log + k], k % NREQ);
        drain();

        // Backpressure on requester 2.
        do_reset();
        base_cnt[2] = issue_cnt[2];
        rsp_ready = 4'b1011;
        req_valid = 4'b0100;
        repeat (15) begin
            rand_ops();
            step();
        end
        check_eq("bp_issues", issue_cnt[2] - base_cnt[2], DEPTH);
        check_eq("bp_ready_low", req_ready[2], 0);
        rsp_ready[2] = 1'b1;
        step();
        rsp_ready[2] = 1'b0;
        repeat (10) step();
        check_eq("bp_one_more", issue_cnt[2] - base_cnt[2], DEPTH + 1);
        check_eq("bp_ready_low2", req_ready[2], 0);
        drain();

        // Random interleave of extreme and small products with random drain.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                case ($urandom_range(0, 2))
                    0: begin
                        req_a[i*LOGA +: LOGA] = LOGA'(1) << 59;
                        req_b[i*LOGB +: LOGB] = LOGB'(1) << 59;
                    end
                    1: begin
                        req_a[i*LOGA +: LOGA] = LOGA'(1);
                        req_b[i*LOGB +: LOGB] = LOGB'(1);
                    end
                    default: begin
                        big = {$urandom(), $urandom()};
                        req_a[i*LOGA +: LOGA] = big[LOGA-1:0];
                        big = {$urandom(), $urandom()};
                        req_b[i*LOGB +: LOGB] = big[LOGB-1:0];
                    end
                endcase
            end
            req_valid = NREQ'($urandom());
            rsp_ready = NREQ'($urandom());
            step();
        end
        drain();
        check_eq("order_no_loss", popped, pushed);
        for (int i = 0; i < NREQ; i++)
            check_eq($sformatf("order_empty%0d", i), q[i].size(), 0);

        // Reset with two operations still inside the multiplier.
        req_a[0 +: LOGA] = LOGA'(11);
        req_b[0 +: LOGB] = LOGB'(13);
        req_a[LOGA +: LOGA] = LOGA'(17);
        req_b[LOGB +: LOGB] = LOGB'(19);
        req_valid = 4'b0011;
        step();
        step();
        req_valid = '0;
        do_reset();
        check_eq("mr_busy", busy, 0);
        repeat (6) begin
            @(negedge clk);
            check_eq("mr_rsp_valid", rsp_valid, 0);
        end
        step();
        req_a[3*LOGA +: LOGA] = LOGA'(7);
        req_b[3*LOGB +: LOGB] = LOGB'(9);
        req_valid = 4'b1000;
        @(negedge clk);
        check_eq("mr_ready", req_ready, 4'b1000);
        step();
        req_valid = '0;
        n = 0;
        found = 1'b0;
        while (n < 20 && !found) begin
            @(negedge clk);
            n++;
            if (rsp_valid[3]) found = 1'b1;
        end
        check_eq("mr_latency", n, LAT + 1);
        check_eq("mr_data", rsp_data[3*PW +: PW], 63);
        step();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/intmul_sched.md
INTMUL_SCHED -- requirements
Module: intmul_sched

Interface
REQ-001 SHALL have parameter LOGA, default 60: operand A width.
REQ-002 SHALL have parameter LOGB, default 60: operand B width.
REQ-003 SHALL have parameter NREQ, default 4: number of requesters, range 2..8.
REQ-004 SHALL have parameter LAT, default 3: fixed latency of the attached multiplier, in cycles (1..8).
REQ-005 SHALL have parameter DEPTH, default 4: result FIFO entries per requester (power of two, at least 2).
REQ-006 SHALL have one clock; reset is synchronous and active-low.
REQ-007 SHALL have port clk, input, 1 bit: clock.
REQ-008 SHALL have port rst, input, 1 bit: synchronous active-low reset.
REQ-009 SHALL have port req_valid, input, NREQ bits: per-requester operand valid.
REQ-010 SHALL have port req_ready, output, NREQ bits: per-requester operand accepted.
REQ-011 SHALL have port req_a, input, NREQ*LOGA bits: packed A operands, requester i at slice i.
REQ-012 SHALL have port req_b, input, NREQ*LOGB bits: packed B operands.
REQ-013 SHALL have port mul_a, output, LOGA bits: operand A to the multiplier.
REQ-014 SHALL have port mul_b, output, LOGB bits: operand B to the multiplier.
REQ-015 SHALL have port mul_c, input, LOGA+LOGB bits: multiplier product.
REQ-016 SHALL have port rsp_valid, output, NREQ bits: per-requester result available.
REQ-017 SHALL have port rsp_ready, input, NREQ bits: per-requester result consumed.
REQ-018 SHALL have port rsp_data, output, NREQ*(LOGA+LOGB) bits: packed results.
REQ-019 SHALL have port busy, output, 1 bit: any operation in flight or buffered.

Function
REQ-020 SHALL issue at most one operation per cycle; issue to i occurs iff req_valid[i] and req_ready[i] are both high.
REQ-021 SHALL treat requester i as eligible iff req_valid[i] is high and credit[i] < DEPTH; credit[i] counts in-flight plus buffered results for i.
REQ-022 SHALL grant the first eligible requester in round-robin order, starting at last_grant+1 modulo NREQ; req_ready is one-hot or zero, and its value depends combinationally on req_valid.
REQ-023 SHALL drive mul_a/mul_b combinationally from the granted operands in the issue cycle and hold them at zero when nothing is issued.
REQ-024 SHALL carry a LAT-deep tag pipeline {valid, id}; the product on mul_c at cycle t+LAT belongs to the issue at cycle t.
REQ-025 SHALL write a tagged product into FIFO[id] at t+LAT, so that rsp_valid[id] rises at t+LAT+1 at the earliest; no bypass path.
REQ-026 SHALL present each FIFO in order on rsp_valid/rsp_data, and pop it when rsp_valid and rsp_ready are both high.
REQ-027 SHALL increment credit on issue and decrement it on pop; when both occur in the same cycle, credit SHALL stay unchanged, so that a FIFO never overflows.
REQ-028 SHALL grant a requester at credit DEPTH-1 that pops in the same cycle; the pop does not create extra credit that cycle.
REQ-029 SHALL wrap FIFO pointers modulo DEPTH and SHALL never write a full FIFO or pop an empty one.
REQ-030 SHALL drive busy high iff any tag stage is valid or any credit is non-zero.
REQ-031 SHALL sustain one result per cycle through the block when all rsp_ready are high.

Reset
REQ-032 SHALL, while rst is low, drive req_ready=0, rsp_valid=0, busy=0, mul_a=0, mul_b=0, and set last_grant=NREQ-1, so that requester 0 has first priority after reset.
REQ-033 SHALL, when reset is asserted mid-operation, clear all tags, credits and FIFO pointers, and ignore any mul_c arriving afterward.

Structure
REQ-034 SHALL take the tag type {valid, id[$clog2(NREQ)-1:0]} and the credit-width constant from the shared package intmul_sched_pkg.
REQ-035 SHALL implement round-robin selection in one sub-module, rr_arbiter (inputs: eligible vector and pointer; output: one-hot grant).

Verification
REQ-036 SHALL check single request: LAT=3, req 0 issues A=3, B=5 at cycle 10 -> rsp_valid[0] at cycle 14 with rsp_data 15.
REQ-037 SHALL check fairness: all 4 valid continuously after reset -> grants in order 0,1,2,3,0,1,... and each requester receives 1/4 of the issues.
REQ-038 SHALL check backpressure: DEPTH=4, rsp_ready[2]=0, req 2 always valid -> exactly 4 issues to 2, then req_ready[2]=0; one pop then allows exactly one more issue.
REQ-039 SHALL check order and simultaneity: interleave products (2^59)*(2^59) and 1*1 across requesters with random rsp_ready -> per-requester results in issue order, full 120-bit values correct, no loss or duplication.
REQ-040 SHALL check mid-flight reset: rst low for 1 cycle with 2 operations in flight -> rsp_valid stays 0, busy=0 after reset, and the next issue returns its own correct result.
